vga_scan_driver: RTL and testbench

//  - Drives the 640x480@60 VGA scan: generates the pixel coordinates consumed by every layer renderer
//    (title screen, tracks, notes), then samples the renderer's 16-bit LayerOutput and emits 12-bit RGB plus syncs.
//  - Sits directly upstream (XPosition/YPosition) and downstream (LayerInput) of the render layers.
//  - Delays syncs/blanking by the renderer latency so colour and sync stay pixel-aligned.

---
 rtl/vga_timing_pkg.sv | 44 ++++
 rtl/scan_delay_line.sv | 51 +++++
 rtl/vga_scan_driver.sv | 148 ++++++++++++++
 tb/tb_vga_scan_driver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 scan timing constants, the per-pixel scan flag type
//   that travels down the renderer-latency delay line, and a window helper.
//   No ports; imported by vga_scan_driver and by layers needing the timing.
package vga_timing_pkg;

   localparam int CLK_DIV_DEF    = 4;   // 100 MHz system clock -> 25 MHz pixel rate
   localparam int PIPE_DELAY_DEF = 2;   // renderer latency in pixel ticks

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

   localparam int H_SYNC_START = H_ACTIVE + H_FP;               // 656
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;         // 752
   localparam int V_SYNC_START = V_ACTIVE + V_FP;               // 490
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;         // 492

   // Flags decoded from the raw scan position; syncs are active low.
   typedef struct packed {
      logic active;
      logic hs_n;
      logic vs_n;
   } scan_flags_t;

   // Blanked, syncs inactive: what the delay line holds out of reset.
   localparam scan_flags_t FLAGS_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

   // Half-open window test lo <= v < hi.
   function automatic logic in_window(input logic [9:0] v,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/scan_delay_line.sv
// scan_delay_line
//   Tick-enabled shift register used to align per-pixel side information
//   with a pipelined renderer.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; every stage loads RESET_VALUE
//   en     in   shift enable (pixel tick)
//   data   in   WIDTH-bit value entering stage 0
//   staged out  value that will move into the last stage on the next shift
//   last   out  last stage (DEPTH shifts behind data)
module scan_delay_line #(
   parameter int               WIDTH       = 3,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] staged,
   output logic [WIDTH-1:0] last
);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("scan_delay_line: DEPTH must be at least 1");
      end
   endgenerate

   logic [DEPTH-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
      end else if (en) begin
         stage[0] <= data;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign last = stage[DEPTH-1];

   // For a single stage the next occupant of the last stage is the input itself.
   generate
      if (DEPTH == 1) begin : g_staged_in
         assign staged = data;
      end else begin : g_staged_tap
         assign staged = stage[DEPTH-2];
      end
   endgenerate

endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver
//   VGA scan generator: pixel divider, X/Y counters feeding the render
//   layers, sync/blank decode delayed by the renderer latency, and the
//   registered 12-bit colour output sampled from the renderer.
//   OriginalClk in   system clock
//   ResetN      in   asynchronous active-low reset
//   LayerInput  in   renderer pixel, R=[15:12] G=[11:8] B=[7:4]
//   XPosition   out  horizontal count 0..H_TOTAL-1
//   YPosition   out  vertical count 0..V_TOTAL-1
//   PixelTick   out  one-cycle strobe per CLK_DIV cycles; counters advance on it
//   FrameStart  out  strobe on the PixelTick that wraps the scan to (0,0)
//   Hsync/Vsync out  active-low syncs, PIPE_DELAY ticks behind the counters
//   Red/Green/Blue out colour, zero while the delayed pixel is blanked
module vga_scan_driver
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV    = CLK_DIV_DEF,
   parameter int PIPE_DELAY = PIPE_DELAY_DEF,
   parameter int H_VIS      = H_ACTIVE,
   parameter int H_FRONT    = H_FP,
   parameter int H_PULSE    = H_SYNC,
   parameter int H_BACK     = H_BP,
   parameter int V_VIS      = V_ACTIVE,
   parameter int V_FRONT    = V_FP,
   parameter int V_PULSE    = V_SYNC,
   parameter int V_BACK     = V_BP
) (
   input  logic        OriginalClk,
   input  logic        ResetN,
   input  logic [15:0] LayerInput,
   output logic [9:0]  XPosition,
   output logic [9:0]  YPosition,
   output logic        PixelTick,
   output logic        FrameStart,
   output logic        Hsync,
   output logic        Vsync,
   output logic [3:0]  Red,
   output logic [3:0]  Green,
   output logic [3:0]  Blue
);

   generate
      if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
         $error("vga_scan_driver: PIPE_DELAY must be in 1..8");
      end
      if (CLK_DIV < 1) begin : g_bad_div
         $error("vga_scan_driver: CLK_DIV must be at least 1");
      end
   endgenerate

   localparam int H_TOT = H_VIS + H_FRONT + H_PULSE + H_BACK;
   localparam int V_TOT = V_VIS + V_FRONT + V_PULSE + V_BACK;

   localparam logic [9:0] X_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] X_VIS    = 10'(H_VIS);
   localparam logic [9:0] Y_VIS    = 10'(V_VIS);
   localparam logic [9:0] HS_START = 10'(H_VIS + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FRONT + H_PULSE);
   localparam logic [9:0] VS_START = 10'(V_VIS + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FRONT + V_PULSE);

   localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic             tick_nxt;

   always_comb begin
      div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      tick_nxt = (div_nxt == DIV_LAST);
   end

   // PixelTick is registered from the next divider value so it is high in
   // exactly the cycle where the divider sits at CLK_DIV-1. FrameStart uses the
   // same look-ahead: X/Y only change on ticks, so they already hold the
   // position that the coming tick will wrap.
   always_ff @(posedge OriginalClk or negedge ResetN) begin
      if (!ResetN) begin
         div_cnt    <= '0;
         PixelTick  <= 1'b0;
         FrameStart <= 1'b0;
         XPosition  <= '0;
         YPosition  <= '0;
      end else begin
         div_cnt    <= div_nxt;
         PixelTick  <= tick_nxt;
         FrameStart <= tick_nxt && (XPosition == X_LAST) && (YPosition == Y_LAST);
         if (PixelTick) begin
            if (XPosition == X_LAST) begin
               XPosition <= '0;
               YPosition <= (YPosition == Y_LAST) ? '0 : YPosition + 10'd1;
            end else begin
               XPosition <= XPosition + 10'd1;
            end
         end
      end
   end

   scan_flags_t raw;
   scan_flags_t staged;
   scan_flags_t delayed;

   always_comb begin
      raw        = FLAGS_IDLE;
      raw.active = (XPosition < X_VIS) && (YPosition < Y_VIS);
      raw.hs_n   = !in_window(XPosition, HS_START, HS_END);
      raw.vs_n   = !in_window(YPosition, VS_START, VS_END);
   end

   scan_delay_line #(
      .WIDTH      ($bits(scan_flags_t)),
      .DEPTH      (PIPE_DELAY),
      .RESET_VALUE(FLAGS_IDLE)
   ) u_delay (
      .clk   (OriginalClk),
      .rst_n (ResetN),
      .en    (PixelTick),
      .data  (raw),
      .staged(staged),
      .last  (delayed)
   );

   assign Hsync = delayed.hs_n;
   assign Vsync = delayed.vs_n;

   // The colour register loads on the same tick that moves `staged` into the
   // last delay stage, so gating with `staged.active` keeps colour aligned
   // with the syncs that appear on that tick.
   logic [11:0] rgb;

   always_ff @(posedge OriginalClk or negedge ResetN) begin
      if (!ResetN) begin
         rgb <= 12'h000;
      end else if (PixelTick) begin
         rgb <= staged.active ? LayerInput[15:4] : 12'h000;
      end
   end

   assign {Red, Green, Blue} = rgb;

   // Low nibble of the renderer word and the sync bits of the staged tap
   // carry no information here.
   logic unused_bits;
   assign unused_bits = ^{LayerInput[3:0], staged.hs_n, staged.vs_n};

endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver
//   Drives one full-timing instance and one shrunken-timing instance in
//   lockstep and compares every output after every clock edge against an
//   arithmetic model of the scan indexed by the number of pixel ticks.
module tb_vga_scan_driver;

   localparam int N = 2;   // 0: default 640x480 timing, 1: shrunken frame
   localparam int HA [N] = '{640, 40};
   localparam int HF [N] = '{16, 4};
   localparam int HS [N] = '{96, 8};
   localparam int HB [N] = '{48, 4};
   localparam int VA [N] = '{480, 30};
   localparam int VF [N] = '{10, 2};
   localparam int VS [N] = '{2, 2};
   localparam int VB [N] = '{33, 3};
   localparam int PD [N] = '{2, 3};
   localparam int DIV = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [15:0]         layer;
   logic [N-1:0][9:0]   xo, yo;
   logic [N-1:0]        tick, fs, hs, vs;
   logic [N-1:0][3:0]   r, g, b;

   int          total = 0;
   int          bad   = 0;
   int          e     = 0;       // clock edges since reset release
   int          mode  = 0;       // 0 random, 1 white, 2 X-nibble renderer
   logic [15:0] lay_upd = '0;    // LayerInput present at the last tick edge
   int          fs_cnt, tick_cnt, x_max, y_max;

   always #5 clk = ~clk;

   vga_scan_driver u_full (
      .OriginalClk(clk), .ResetN(rst_n), .LayerInput(layer),
      .XPosition(xo[0]), .YPosition(yo[0]), .PixelTick(tick[0]), .FrameStart(fs[0]),
      .Hsync(hs[0]), .Vsync(vs[0]), .Red(r[0]), .Green(g[0]), .Blue(b[0])
   );

   vga_scan_driver #(
      .PIPE_DELAY(3),
      .H_VIS(40), .H_FRONT(4), .H_PULSE(8), .H_BACK(4),
      .V_VIS(30), .V_FRONT(2), .V_PULSE(2), .V_BACK(3)
   ) u_small (
      .OriginalClk(clk), .ResetN(rst_n), .LayerInput(layer),
      .XPosition(xo[1]), .YPosition(yo[1]), .PixelTick(tick[1]), .FrameStart(fs[1]),
      .Hsync(hs[1]), .Vsync(vs[1]), .Red(r[1]), .Green(g[1]), .Blue(b[1])
   );

   typedef struct {
      logic tick, fs, hs, vs, gate;
      int   x, y;
   } exp_t;

   // After `edges` clocks, n = edges/DIV coordinate steps have happened; the
   // scan position is n in raster order and the syncs/colour show position n-PD.
   function automatic exp_t model(input int p, input int edges);
      exp_t m;
      int ht, vt, n, d, dx, dy;
      ht     = HA[p] + HF[p] + HS[p] + HB[p];
      vt     = VA[p] + VF[p] + VS[p] + VB[p];
      n      = edges / DIV;
      m.x    = n % ht;
      m.y    = (n / ht) % vt;
      m.tick = (edges % DIV) == DIV - 1;
      m.fs   = m.tick && (m.x == ht - 1) && (m.y == vt - 1);
      m.hs   = 1'b1;
      m.vs   = 1'b1;
      m.gate = 1'b0;
      if (n >= PD[p]) begin
         d      = n - PD[p];
         dx     = d % ht;
         dy     = (d / ht) % vt;
         m.gate = (dx < HA[p]) && (dy < VA[p]);
         m.hs   = !((dx >= HA[p] + HF[p]) && (dx < HA[p] + HF[p] + HS[p]));
         m.vs   = !((dy >= VA[p] + VF[p]) && (dy < VA[p] + VF[p] + VS[p]));
      end
      return m;
   endfunction

   task automatic chk(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h (edge %0d)", tag, p, obs, exp, e);
      end
   endtask

   task automatic check_all();
      exp_t        m;
      logic [11:0] rgb;
      for (int p = 0; p < N; p++) begin
         m   = model(p, e);
         rgb = m.gate ? lay_upd[15:4] : 12'h000;
         chk("tick",   p, 32'(tick[p]), 32'(m.tick));
         chk("frame",  p, 32'(fs[p]),   32'(m.fs));
         chk("x",      p, 32'(xo[p]),   32'(m.x));
         chk("y",      p, 32'(yo[p]),   32'(m.y));
         chk("hsync",  p, 32'(hs[p]),   32'(m.hs));
         chk("vsync",  p, 32'(vs[p]),   32'(m.vs));
         chk("rgb",    p, 32'({r[p], g[p], b[p]}), 32'(rgb));
      end
   endtask

   task automatic chk_reset(input string tag);
      for (int p = 0; p < N; p++) begin
         chk({tag, "_x"},     p, 32'(xo[p]),   32'd0);
         chk({tag, "_y"},     p, 32'(yo[p]),   32'd0);
         chk({tag, "_tick"},  p, 32'(tick[p]), 32'd0);
         chk({tag, "_frame"}, p, 32'(fs[p]),   32'd0);
         chk({tag, "_hsync"}, p, 32'(hs[p]),   32'd1);
         chk({tag, "_vsync"}, p, 32'(vs[p]),   32'd1);
         chk({tag, "_rgb"},   p, 32'({r[p], g[p], b[p]}), 32'd0);
      end
   endtask

   // One clock: pick LayerInput (random between ticks, mode value on tick
   // edges), clock, then sample 1 time unit after the edge.
   task automatic step();
      logic [15:0] v;
      exp_t        m;
      int          nn;
      v = 16'($urandom);
      if ((e + 1) % DIV == 0) begin
         nn = (e + 1) / DIV;
         if (mode == 1) v = 16'hfff0;
         else if (mode == 2) v = {4'((nn - PD[0]) % 800), 12'h000};
         lay_upd = v;
      end
      layer = v;
      @(posedge clk);
      e++;
      #1;
      check_all();
      if (mode == 2 && e % DIV == 0) begin
         m = model(0, e);
         if (m.gate) chk("red_lag", 0, 32'(r[0]), 32'((m.x - 2) & 15));
      end
      if (mode == 1) begin
         if (fs[1])   fs_cnt++;
         if (tick[1]) tick_cnt++;
         if (int'(xo[1]) > x_max) x_max = int'(xo[1]);
         if (int'(yo[1]) > y_max) y_max = int'(yo[1]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      layer = 16'h0;
      repeat (10) @(posedge clk);
      #1 chk_reset("rst_hold");

      @(negedge clk) rst_n = 1'b1;
      e = 0;
      #1 check_all();

      // Random pixels until the full-timing scan sits at (300,1), one clock past a tick.
      repeat (4401) step();
      #1 rst_n = 1'b0;
      #1 chk_reset("rst_mid");
      repeat (3) @(posedge clk);
      #1 chk_reset("rst_held");
      @(negedge clk) rst_n = 1'b1;
      e = 0;
      #1 check_all();

      // Exactly one shrunken frame (56x37 ticks) of white input.
      mode     = 1;
      fs_cnt   = 0;
      tick_cnt = 0;
      x_max    = 0;
      y_max    = 0;
      repeat (56 * 37 * DIV) step();
      chk("frame_starts", 1, 32'(fs_cnt),   32'd1);
      chk("tick_count",   1, 32'(tick_cnt), 32'(56 * 37));
      chk("x_max",        1, 32'(x_max),    32'd55);
      chk("y_max",        1, 32'(y_max),    32'd36);

      // Renderer returning X[3:0] with PIPE_DELAY ticks of latency.
      mode = 2;
      repeat (3300) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
